// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial-controller state encoding and nibble saturation constants.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [NIBBLE_W-1:0] SAT_NEG = 4'b1000;

endpackage

// File: rtl/sub_sat_4bit.sv
// Combinational signed 4-bit subtract (a - b) that clamps to the 4-bit range on overflow.
module sub_sat_4bit
  import alu_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic [NIBBLE_W-1:0] d,
  output logic                ovf
);

  logic [NIBBLE_W-1:0] diff;

  // Two's complement subtract; the carry out is not needed.
  assign diff = a + ~b + 4'd1;
  assign ovf  = (a[3] != b[3]) && (diff[3] != a[3]);

  always_comb begin
    d = diff;
    if (ovf) begin
      d = a[3] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/psub_serial.sv
// Nibble-serial saturating sub-word subtractor: one shared 4-bit slice walks the
// nibbles of A - B, one nibble per clock, then pulses done.
//
// Handshake: start is a request sampled only in IDLE; while busy or during the
// done cycle it is ignored. done is a single-cycle pulse, and Result/Ovfl stay
// valid from that cycle until the next operation writes its first nibble.
module psub_serial
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] Result,
  output logic [NIBBLES-1:0]          Ovfl
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  state_t              state_next;
  logic [IW-1:0]       idx;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_d;
  logic                nib_ovf;
  logic                last_nib;

  assign last_nib = (idx == IW'(NIBBLES - 1));
  assign nib_a    = a_q[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b    = b_q[idx*NIBBLE_W +: NIBBLE_W];

  sub_sat_4bit u_slice (
    .a   (nib_a),
    .b   (nib_b),
    .d   (nib_d),
    .ovf (nib_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_nib) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operands are captured only on an accepted start; Result/Ovfl only change in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      Result <= '0;
      Ovfl   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q <= A;
            b_q <= B;
            idx <= '0;
          end
        end
        ST_RUN: begin
          Result[idx*NIBBLE_W +: NIBBLE_W] <= nib_d;
          Ovfl[idx]                        <= nib_ovf;
          idx                              <= last_nib ? '0 : idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psub_serial.sv
// Bench for psub_serial: scenario tasks with a queue of expected {Ovfl, Result} words.
module tb_psub_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  ovfl;

  int vectors = 0;
  int miscompares = 0;
  logic [19:0] exp_q[$];

  psub_serial #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (a_in),
    .B      (b_in),
    .busy   (busy),
    .done   (done),
    .Result (result),
    .Ovfl   (ovfl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed integer difference per nibble, clamped to [-8, 7].
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0]       r;
    logic [3:0]        o;
    logic signed [3:0] sa;
    logic signed [3:0] sb;
    int                dif;
    r = '0;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      sa  = a[4*i +: 4];
      sb  = b[4*i +: 4];
      dif = int'(sa) - int'(sb);
      if (dif > 7) begin
        r[4*i +: 4] = 4'h7;
        o[i] = 1'b1;
      end else if (dif < -8) begin
        r[4*i +: 4] = 4'h8;
        o[i] = 1'b1;
      end else begin
        r[4*i +: 4] = 4'(dif);
      end
    end
    return {o, r};
  endfunction

  // Pulses start for one sampling edge and records the expected outcome.
  task automatic drive_start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done appears (bounded); returns on the done cycle.
  task automatic wait_done(output int run_cycles, output bit seen);
    run_cycles = 0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) run_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (result !== 16'h0000 || ovfl !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_initial: result=%h ovfl=%b busy=%b done=%b, want 0000 0000 0 0",
               result, ovfl, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int run_cycles;
    bit seen;
    logic [19:0] exp;
    drive_start(16'h1234, 16'h1111);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_after_start: busy=%b, want 1", busy);
    end
    wait_done(run_cycles, seen);
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL basic_done_timeout: done=%b, want 1 within 20 cycles", done);
    end
    vectors++;
    if (run_cycles !== 4) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, want 4", run_cycles);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_busy_with_done: busy=%b, want 0", busy);
    end
    exp = exp_q.pop_front();
    vectors++;
    if ({ovfl, result} !== exp || result !== 16'h0123 || ovfl !== 4'b0000) begin
      miscompares++;
      $display("FAIL basic_result: got %b/%h, want %b/%h", ovfl, result, exp[19:16], exp[15:0]);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || result !== 16'h0123) begin
      miscompares++;
      $display("FAIL basic_done_pulse_hold: done=%b result=%h, want 0 and 0123 held", done, result);
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 16'h0000 || ovfl !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: result=%h ovfl=%b busy=%b done=%b, want 0000 0000 0 0",
               result, ovfl, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    int run_cycles;
    bit seen;
    logic [19:0] exp;
    drive_start(16'h7830, 16'hF150);
    wait_done(run_cycles, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || {ovfl, result} !== exp || result !== 16'h78E0 || ovfl !== 4'b1100) begin
      miscompares++;
      $display("FAIL saturation: done_seen=%b got %b/%h, want 1100/78e0", seen, ovfl, result);
    end
  endtask

  task automatic test_ignored_start;
    int done_at[$];
    logic [19:0] exp;
    logic [15:0] ra;
    logic [15:0] rb;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (done && busy) begin
        miscompares++;
        $display("FAIL ignored_done_busy_overlap: cycle %0d done=%b busy=%b, want not both", c, done, busy);
      end
      if (done) begin
        done_at.push_back(c);
        exp = exp_q.pop_front();
        vectors++;
        if ({ovfl, result} !== exp) begin
          miscompares++;
          $display("FAIL ignored_result: cycle %0d got %b/%h, want %b/%h",
                   c, ovfl, result, exp[19:16], exp[15:0]);
        end
      end
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      a_in  = ra;
      b_in  = rb;
      start = 1'b1;
      if (c == 0 || c == 6) exp_q.push_back(model(ra, rb));
    end
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (done_at.size() != 2) begin
      miscompares++;
      $display("FAIL ignored_done_count: got %0d, want 2", done_at.size());
    end else begin
      vectors++;
      if (done_at[1] - done_at[0] != 6 || done_at[0] != 5) begin
        miscompares++;
        $display("FAIL ignored_done_spacing: first=%0d spacing=%0d, want 5 and 6",
                 done_at[0], done_at[1] - done_at[0]);
      end
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int run_cycles;
    bit seen;
    bit stray_done;
    logic [19:0] exp;
    drive_start(16'h5A5A, 16'h1234);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || ovfl !== 4'b0000) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b result=%h ovfl=%b, want 0 0 0000 0000",
               busy, done, result, ovfl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) stray_done = 1'b1;
    end
    vectors++;
    if (stray_done) begin
      miscompares++;
      $display("FAIL midrun_no_resume: activity after aborted run=1, want 0");
    end
    drive_start(16'h8000, 16'h1000);
    wait_done(run_cycles, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || {ovfl, result} !== exp || result !== 16'h8000 || ovfl !== 4'b1000) begin
      miscompares++;
      $display("FAIL midrun_next_op: done_seen=%b got %b/%h, want 1000/8000", seen, ovfl, result);
    end
  endtask

  task automatic test_boundaries;
    logic [15:0] ta[2];
    logic [15:0] tb[2];
    logic [19:0] tw[2];
    int run_cycles;
    bit seen;
    logic [19:0] exp;
    ta[0] = 16'h0000; tb[0] = 16'h8888; tw[0] = {4'b1111, 16'h7777};
    ta[1] = 16'h8888; tb[1] = 16'h8888; tw[1] = {4'b0000, 16'h0000};
    for (int i = 0; i < 2; i++) begin
      drive_start(ta[i], tb[i]);
      wait_done(run_cycles, seen);
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || {ovfl, result} !== exp || {ovfl, result} !== tw[i]) begin
        miscompares++;
        $display("FAIL boundary_%0d: done_seen=%b got %b/%h, want %b/%h",
                 i, seen, ovfl, result, tw[i][19:16], tw[i][15:0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int run_cycles;
    bit seen;
    logic [19:0] exp;
    for (int i = 0; i < 8; i++) begin
      drive_start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
      wait_done(run_cycles, seen);
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || run_cycles != 4 || {ovfl, result} !== exp) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: seen=%b cycles=%0d got %b/%h, want 1 4 %b/%h",
                 i, seen, run_cycles, ovfl, result, exp[19:16], exp[15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_async_reset();
    test_saturation();
    test_ignored_start();
    test_reset_mid_run();
    test_boundaries();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
